bin_maxpool2x2_mc: RTL and testbench



---
 rtl/bin_maxpool2x2_mc_pkg.sv | 20 ++
 rtl/bin_maxpool2x2_mc_if.sv | 38 +++
 rtl/bin_maxpool2x2_mc_line_buf.sv | 24 ++
 rtl/bin_maxpool2x2_mc.sv | 160 ++++++++++++++++
 tb/tb_bin_maxpool2x2_mc.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bin_maxpool2x2_mc_pkg.sv
// Shared types and defaults for the binarised 2x2 pooling stage.
// Optional stride-1 support is selected with MPOOL_STRIDE1_EN.
package bin_pool_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int CH_DEF    = 8;
    localparam int MAX_W_DEF = 28;
    localparam int MAX_H_DEF = 28;

    // Never returns 0, so degenerate sizes still give a legal vector width.
    function automatic int safe_clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bin_maxpool2x2_mc_if.sv
// Pixel-stream and frame-control bundle for bin_maxpool2x2_mc.
// iSTRIDE1 exists only when MPOOL_STRIDE1_EN is defined.
interface bin_maxpool2x2_mc_if #(
    parameter int CH = bin_pool_pkg::CH_DEF,
    parameter int WW = bin_pool_pkg::safe_clog2(bin_pool_pkg::MAX_W_DEF + 1),
    parameter int HW = bin_pool_pkg::safe_clog2(bin_pool_pkg::MAX_H_DEF + 1)
);
    logic          iSTART;
    logic [WW-1:0] iWIDTH;
    logic [HW-1:0] iHEIGHT;
    logic          iVALID;
    logic [CH-1:0] iDATA;
`ifdef MPOOL_STRIDE1_EN
    logic          iSTRIDE1;
`endif
    logic          oVALID;
    logic [CH-1:0] oDATA_OR;
    logic [CH-1:0] oDATA_AND;
    logic          oBUSY;
    logic          oDONE;

    modport slave (
        input  iSTART, iWIDTH, iHEIGHT, iVALID, iDATA,
`ifdef MPOOL_STRIDE1_EN
        input  iSTRIDE1,
`endif
        output oVALID, oDATA_OR, oDATA_AND, oBUSY, oDONE
    );

    modport master (
        output iSTART, iWIDTH, iHEIGHT, iVALID, iDATA,
`ifdef MPOOL_STRIDE1_EN
        output iSTRIDE1,
`endif
        input  oVALID, oDATA_OR, oDATA_AND, oBUSY, oDONE
    );

endinterface

// File: rtl/bin_maxpool2x2_mc_line_buf.sv
// One-row pixel store: asynchronous read and synchronous write at a shared
// address, so the read returns the previous row's pixel in the write cycle.
module mp_line_buf #(
    parameter int WL    = bin_pool_pkg::CH_DEF,
    parameter int DEPTH = bin_pool_pkg::MAX_W_DEF,
    parameter int AW    = bin_pool_pkg::safe_clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [AW-1:0] addr,
    input  logic [WL-1:0] wdata,
    output logic [WL-1:0] rdata
);
    logic [WL-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (en) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/bin_maxpool2x2_mc.sv
// Streaming 2x2 OR/AND pool over CH-bit binarised pixels with runtime frame size.
// Define MPOOL_STRIDE1_EN to add the iSTRIDE1 overlapping-window mode.
module bin_maxpool2x2_mc #(
    parameter int CH    = bin_pool_pkg::CH_DEF,
    parameter int MAX_W = bin_pool_pkg::MAX_W_DEF,
    parameter int MAX_H = bin_pool_pkg::MAX_H_DEF,
    parameter int WW    = bin_pool_pkg::safe_clog2(MAX_W + 1),
    parameter int HW    = bin_pool_pkg::safe_clog2(MAX_H + 1)
) (
    input  logic iCLK,
    input  logic iRST,
    bin_maxpool2x2_mc_if.slave bus
);
    import bin_pool_pkg::*;

    localparam int AW = safe_clog2(MAX_W);

    state_e        state_q, state_d;
    logic [WW-1:0] col_q, col_d, w_q, w_d;
    logic [HW-1:0] row_q, row_d, h_q, h_d;
    logic [CH-1:0] cur_q, cur_d, up_q, up_d;
    logic          ovalid_q, ovalid_d;
    logic [CH-1:0] oor_q, oor_d, oand_q, oand_d;
    logic          busy_q, busy_d, done_q, done_d;
`ifdef MPOOL_STRIDE1_EN
    logic          stride1_q, stride1_d;
`endif

    logic [CH-1:0] lb_rd, pool_or, pool_and;
    logic          accept, size_ok, win_done, last_col, last_row;

    assign size_ok  = (bus.iWIDTH  >= WW'(2)) && (bus.iWIDTH  <= WW'(MAX_W)) &&
                      (bus.iHEIGHT >= HW'(2)) && (bus.iHEIGHT <= HW'(MAX_H));
    assign accept   = (state_q == ST_RUN) && bus.iVALID && !bus.iSTART;
    assign last_col = (col_q == w_q - WW'(1));
    assign last_row = (row_q == h_q - HW'(1));

`ifdef MPOOL_STRIDE1_EN
    assign win_done = stride1_q ? ((row_q != '0) && (col_q != '0)) : (row_q[0] && col_q[0]);
`else
    assign win_done = row_q[0] && col_q[0];
`endif

    mp_line_buf #(
        .WL    (CH),
        .DEPTH (MAX_W),
        .AW    (AW)
    ) u_line_buf (
        .clk   (iCLK),
        .en    (accept),
        .addr  (col_q[AW-1:0]),
        .wdata (bus.iDATA),
        .rdata (lb_rd)
    );

    // The window is formed from this cycle's pixel and line-buffer read plus
    // the previous ones, so the "delayed" window taps are simply cur_q/up_q.
    genvar gi;
    for (gi = 0; gi < CH; gi++) begin : g_pool
        assign pool_or[gi]  = bus.iDATA[gi] | cur_q[gi] | lb_rd[gi] | up_q[gi];
        assign pool_and[gi] = bus.iDATA[gi] & cur_q[gi] & lb_rd[gi] & up_q[gi];
    end

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        w_d      = w_q;
        h_d      = h_q;
        cur_d    = cur_q;
        up_d     = up_q;
        ovalid_d = 1'b0;
        oor_d    = oor_q;
        oand_d   = oand_q;
`ifdef MPOOL_STRIDE1_EN
        stride1_d = stride1_q;
`endif
        if (bus.iSTART) begin
            w_d     = bus.iWIDTH;
            h_d     = bus.iHEIGHT;
            col_d   = '0;
            row_d   = '0;
            state_d = size_ok ? ST_RUN : ST_DONE;
`ifdef MPOOL_STRIDE1_EN
            stride1_d = bus.iSTRIDE1;
`endif
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_RUN: begin
                    if (accept) begin
                        cur_d = bus.iDATA;
                        up_d  = lb_rd;
                        if (win_done) begin
                            ovalid_d = 1'b1;
                            oor_d    = pool_or;
                            oand_d   = pool_and;
                        end
                        if (last_col) begin
                            col_d = '0;
                            row_d = row_q + HW'(1);
                            if (last_row) begin
                                state_d = ST_DONE;
                            end
                        end else begin
                            col_d = col_q + WW'(1);
                        end
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q  <= ST_IDLE;
            col_q    <= '0;
            row_q    <= '0;
            w_q      <= '0;
            h_q      <= '0;
            cur_q    <= '0;
            up_q     <= '0;
            ovalid_q <= 1'b0;
            oor_q    <= '0;
            oand_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef MPOOL_STRIDE1_EN
            stride1_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            w_q      <= w_d;
            h_q      <= h_d;
            cur_q    <= cur_d;
            up_q     <= up_d;
            ovalid_q <= ovalid_d;
            oor_q    <= oor_d;
            oand_q   <= oand_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef MPOOL_STRIDE1_EN
            stride1_q <= stride1_d;
`endif
        end
    end

    assign bus.oVALID    = ovalid_q;
    assign bus.oDATA_OR  = oor_q;
    assign bus.oDATA_AND = oand_q;
    assign bus.oBUSY     = busy_q;
    assign bus.oDONE     = done_q;

endmodule

// File: tb/tb_bin_maxpool2x2_mc.sv
// Directed-plus-random bench for bin_maxpool2x2_mc; expected windows are taken
// straight from a stored copy of each frame.
module tb_bin_maxpool2x2_mc;
    import bin_pool_pkg::*;

    localparam int CH    = CH_DEF;
    localparam int MAX_W = MAX_W_DEF;
    localparam int MAX_H = MAX_H_DEF;
    localparam int WW    = safe_clog2(MAX_W + 1);
    localparam int HW    = safe_clog2(MAX_H + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bin_maxpool2x2_mc_if #(.CH(CH), .WW(WW), .HW(HW)) bus ();

    bin_maxpool2x2_mc #(
        .CH(CH), .MAX_W(MAX_W), .MAX_H(MAX_H), .WW(WW), .HW(HW)
    ) dut (
        .iCLK (clk),
        .iRST (rst),
        .bus  (bus)
    );

    int            n_assert = 0;
    int            n_fail   = 0;
    int            n_out;
    logic [CH-1:0] pix [MAX_H][MAX_W];
    logic [CH-1:0] exp_or_last  = '0;
    logic [CH-1:0] exp_and_last = '0;
    logic [CH-1:0] out_or_q [$];
    logic [CH-1:0] out_and_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input int w, input int h, input int mode);
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                pix[r][c] = (mode == 1) ? {CH{1'b1}} : CH'($urandom);
    endtask

    // Drive iSTART for one cycle; illegal sizes must go straight to DONE.
    task automatic start(input int w, input int h);
        logic legal;
        legal = (w >= 2) && (w <= MAX_W) && (h >= 2) && (h <= MAX_H);
        bus.iSTART  = 1'b1;
        bus.iWIDTH  = WW'(w);
        bus.iHEIGHT = HW'(h);
        bus.iVALID  = 1'($urandom);
        bus.iDATA   = CH'($urandom);
        @(negedge clk);
        bus.iSTART = 1'b0;
        bus.iVALID = 1'b0;
        check("start_valid", 32'(bus.oVALID), 32'(0));
        check("start_busy",  32'(bus.oBUSY),  32'(legal));
        check("start_done",  32'(bus.oDONE),  32'(!legal));
        $display("start w=%0d h=%0d legal=%0d", w, h, legal);
    endtask

    // Cycles where nothing may be accepted (IDLE/after reset).
    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            bus.iVALID = 1'b1;
            bus.iDATA  = CH'($urandom);
            @(negedge clk);
            check("idle_valid", 32'(bus.oVALID), 32'(0));
            check("idle_busy",  32'(bus.oBUSY),  32'(0));
            check("idle_done",  32'(bus.oDONE),  32'(0));
        end
        bus.iVALID = 1'b0;
    endtask

    // gap_mode: 0 none, 1 one idle cycle between pixels, 2 random idles.
    // limit < 0 streams the whole frame.
    task automatic stream(input int w, input int h, input int gap_mode, input int limit);
        int            n;
        int            gaps;
        logic          win;
        logic          last;
        logic [CH-1:0] eo, ea;
        n = 0;
        n_out = 0;
        out_or_q.delete();
        out_and_q.delete();
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                if (limit >= 0 && n >= limit) begin
                    bus.iVALID = 1'b0;
                    return;
                end
                if (gap_mode == 1)      gaps = (n > 0) ? 1 : 0;
                else if (gap_mode == 2) gaps = int'($urandom_range(0, 2));
                else                    gaps = 0;
                for (int g = 0; g < gaps; g++) begin
                    bus.iVALID = 1'b0;
                    bus.iDATA  = CH'($urandom);
                    @(negedge clk);
                    check("gap_valid",    32'(bus.oVALID),    32'(0));
                    check("gap_busy",     32'(bus.oBUSY),     32'(1));
                    check("gap_hold_or",  32'(bus.oDATA_OR),  32'(exp_or_last));
                    check("gap_hold_and", 32'(bus.oDATA_AND), 32'(exp_and_last));
                end
                bus.iVALID = 1'b1;
                bus.iDATA  = pix[r][c];
                @(negedge clk);
                n++;
                win  = (r % 2 == 1) && (c % 2 == 1);
                last = (r == h - 1) && (c == w - 1);
                check("acc_valid", 32'(bus.oVALID), 32'(win));
                check("acc_done",  32'(bus.oDONE),  32'(last));
                check("acc_busy",  32'(bus.oBUSY),  32'(!last));
                if (win) begin
                    eo = pix[r-1][c-1] | pix[r-1][c] | pix[r][c-1] | pix[r][c];
                    ea = pix[r-1][c-1] & pix[r-1][c] & pix[r][c-1] & pix[r][c];
                    check("win_or",  32'(bus.oDATA_OR),  32'(eo));
                    check("win_and", 32'(bus.oDATA_AND), 32'(ea));
                    exp_or_last  = eo;
                    exp_and_last = ea;
                    n_out++;
                    out_or_q.push_back(bus.oDATA_OR);
                    out_and_q.push_back(bus.oDATA_AND);
                    $display("window row=%0d col=%0d or=%h and=%h", r, c, bus.oDATA_OR, bus.oDATA_AND);
                end else begin
                    check("hold_or",  32'(bus.oDATA_OR),  32'(exp_or_last));
                    check("hold_and", 32'(bus.oDATA_AND), 32'(exp_and_last));
                end
            end
        end
        bus.iVALID = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad_w [5] = '{1, MAX_W + 1, 4, 4, 0};
        int bad_h [5] = '{4, 4, 1, MAX_H + 1, 0};

        rst         = 1'b1;
        bus.iSTART  = 1'b0;
        bus.iWIDTH  = '0;
        bus.iHEIGHT = '0;
        bus.iVALID  = 1'b0;
        bus.iDATA   = '0;
`ifdef MPOOL_STRIDE1_EN
        bus.iSTRIDE1 = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(bus.oVALID),    32'(0));
        check("rst_busy",  32'(bus.oBUSY),     32'(0));
        check("rst_done",  32'(bus.oDONE),     32'(0));
        check("rst_or",    32'(bus.oDATA_OR),  32'(0));
        check("rst_and",   32'(bus.oDATA_AND), 32'(0));
        rst = 1'b0;
        idle_check(3);

        // All-ones 4x4: four windows, last one together with oDONE.
        start(4, 4);
        fill(4, 4, 1);
        stream(4, 4, 0, -1);
        check("ones_count", 32'(n_out), 32'(4));
        check("ones_or0",   32'(out_or_q[0]),  32'(8'hFF));
        check("ones_and3",  32'(out_and_q[3]), 32'(8'hFF));

        // One-hot 4x2, restarted straight out of DONE.
        start(4, 2);
        pix[0][0] = 8'h01; pix[0][1] = 8'h02; pix[0][2] = 8'h04; pix[0][3] = 8'h08;
        pix[1][0] = 8'h10; pix[1][1] = 8'h20; pix[1][2] = 8'h40; pix[1][3] = 8'h80;
        stream(4, 2, 0, -1);
        check("hot_count", 32'(n_out),         32'(2));
        check("hot_or0",   32'(out_or_q[0]),   32'(8'h33));
        check("hot_and0",  32'(out_and_q[0]),  32'(8'h00));
        check("hot_or1",   32'(out_or_q[1]),   32'(8'hCC));
        check("hot_and1",  32'(out_and_q[1]),  32'(8'h00));
        idle_check(2);

        // Odd 5x3 with alternating valid.
        start(5, 3);
        fill(5, 3, 0);
        stream(5, 3, 1, -1);
        check("odd_count", 32'(n_out), 32'(2));
        idle_check(1);

        // Abort after 7 pixels, then a fresh 6x4 frame with random gaps.
        start(4, 4);
        fill(4, 4, 0);
        stream(4, 4, 0, 7);
        start(6, 4);
        fill(6, 4, 0);
        stream(6, 4, 2, -1);
        check("restart_count", 32'(n_out), 32'(6));
        idle_check(1);

        // Illegal sizes give a lone oDONE and nothing else.
        for (int i = 0; i < 5; i++) begin
            start(bad_w[i], bad_h[i]);
            idle_check(2);
        end

        // Size boundaries.
        start(2, 2);
        fill(2, 2, 0);
        stream(2, 2, 0, -1);
        check("min_count", 32'(n_out), 32'(1));
        idle_check(1);
        start(MAX_W, 5);
        fill(MAX_W, 5, 0);
        stream(MAX_W, 5, 2, -1);
        check("maxw_count", 32'(n_out), 32'((MAX_W / 2) * 2));
        idle_check(1);
        start(7, MAX_H);
        fill(7, MAX_H, 0);
        stream(7, MAX_H, 0, -1);
        check("maxh_count", 32'(n_out), 32'(3 * (MAX_H / 2)));
        idle_check(1);

        // Asynchronous reset while oVALID and oBUSY are high.
        start(4, 4);
        fill(4, 4, 0);
        stream(4, 4, 0, 6);
        #1 rst = 1'b1;
        #1;
        check("arst_valid", 32'(bus.oVALID),   32'(0));
        check("arst_busy",  32'(bus.oBUSY),    32'(0));
        check("arst_done",  32'(bus.oDONE),    32'(0));
        check("arst_or",    32'(bus.oDATA_OR), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        exp_or_last  = '0;
        exp_and_last = '0;
        idle_check(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
